// File: rtl/ddr_cmd_timing_gate.sv
// DDR command timing gate: forwards timing-legal commands to the DFI stage
// through one registered output slot, drops state-illegal ones with err_pulse.
module ddr_cmd_timing_gate #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_W    = 17,
    parameter int tRCD_CYC  = 14,
    parameter int tRP_CYC   = 14,
    parameter int tRAS_CYC  = 32,
    parameter int tCCD_CYC  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [$clog2(NUM_BANKS)-1:0] in_bank,
    input  logic [ADDR_W-1:0]            in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_op,
    output logic [$clog2(NUM_BANKS)-1:0] out_bank,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         err_pulse,
    output logic                         stall
);
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int M1   = (tRCD_CYC > tRP_CYC) ? tRCD_CYC : tRP_CYC;
    localparam int M2   = (tRAS_CYC > tCCD_CYC) ? tRAS_CYC : tCCD_CYC;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ACT = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_WR  = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4;
    localparam logic [2:0] OP_REF = 3'd5;

    // Loads count the wait after the issuing cycle, so a pair N apart is legal.
    localparam cnt_t RCD_LD = cnt_t'((tRCD_CYC > 0) ? tRCD_CYC - 1 : 0);
    localparam cnt_t RP_LD  = cnt_t'((tRP_CYC > 0) ? tRP_CYC - 1 : 0);
    localparam cnt_t RAS_LD = cnt_t'((tRAS_CYC > 0) ? tRAS_CYC - 1 : 0);
    localparam cnt_t CCD_LD = cnt_t'((tCCD_CYC > 0) ? tCCD_CYC - 1 : 0);

    logic [NUM_BANKS-1:0] open_q, open_d;
    cnt_t                 rcd_q [NUM_BANKS];
    cnt_t                 rcd_d [NUM_BANKS];
    cnt_t                 rp_q  [NUM_BANKS];
    cnt_t                 rp_d  [NUM_BANKS];
    cnt_t                 ras_q [NUM_BANKS];
    cnt_t                 ras_d [NUM_BANKS];
    cnt_t                 ccd_q, ccd_d;

    logic                 out_valid_q, out_valid_d;
    logic [2:0]           out_op_q, out_op_d;
    logic [BW-1:0]        out_bank_q, out_bank_d;
    logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
    logic                 err_q, err_d;

    logic                 sel_open, rp_all_zero;
    logic                 wait_t, bad, out_free, accept, fwd;

    function automatic cnt_t dec(input cnt_t c);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

    always_comb begin
        sel_open    = open_q[in_bank];
        rp_all_zero = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rp_q[i] != '0) rp_all_zero = 1'b0;
        end
    end

    always_comb begin
        wait_t = 1'b0;
        bad    = 1'b0;
        case (in_op)
            OP_NOP: wait_t = 1'b0;
            OP_ACT: begin
                bad    = sel_open;
                wait_t = !sel_open && (rp_q[in_bank] != '0);
            end
            OP_RD, OP_WR: begin
                bad    = !sel_open;
                wait_t = sel_open && ((rcd_q[in_bank] != '0) || (ccd_q != '0));
            end
            OP_PRE: begin
                bad    = !sel_open;
                wait_t = sel_open && (ras_q[in_bank] != '0);
            end
            OP_REF: wait_t = (open_q != '0) || !rp_all_zero;
            default: bad = 1'b1;
        endcase
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !wait_t && out_free;
    assign accept   = in_valid && in_ready;
    assign fwd      = accept && !bad && (in_op != OP_NOP);

    always_comb begin
        open_d = open_q;
        ccd_d  = dec(ccd_q);
        for (int i = 0; i < NUM_BANKS; i++) begin
            rcd_d[i] = dec(rcd_q[i]);
            rp_d[i]  = dec(rp_q[i]);
            ras_d[i] = dec(ras_q[i]);
        end
        if (fwd) begin
            case (in_op)
                OP_ACT: begin
                    open_d[in_bank] = 1'b1;
                    rcd_d[in_bank]  = RCD_LD;
                    ras_d[in_bank]  = RAS_LD;
                end
                OP_RD, OP_WR: ccd_d = CCD_LD;
                OP_PRE: begin
                    open_d[in_bank] = 1'b0;
                    rp_d[in_bank]   = RP_LD;
                end
                default: ccd_d = dec(ccd_q);
            endcase
        end
    end

    always_comb begin
        out_valid_d = fwd ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_op_d    = fwd ? in_op : out_op_q;
        out_bank_d  = fwd ? in_bank : out_bank_q;
        out_addr_d  = fwd ? in_addr : out_addr_q;
        err_d       = accept && bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q      <= '0;
            ccd_q       <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
                ras_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_bank_q  <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            open_q      <= open_d;
            ccd_q       <= ccd_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_q[i] <= rcd_d[i];
                rp_q[i]  <= rp_d[i];
                ras_q[i] <= ras_d[i];
            end
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_bank_q  <= out_bank_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_bank  = out_bank_q;
    assign out_addr  = out_addr_q;
    assign bank_open = open_q;
    assign err_pulse = err_q;
    assign stall     = in_valid && !in_ready;
endmodule

// File: tb/tb_ddr_cmd_timing_gate.sv
// Bench for ddr_cmd_timing_gate: directed timing scenarios plus random
// traffic against an absolute-cycle reference model.
module tb_ddr_cmd_timing_gate;
    localparam int NB = 8;
    localparam int AW = 17;
    localparam int T_RCD = 14;
    localparam int T_RP = 14;
    localparam int T_RAS = 32;
    localparam int T_CCD = 4;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ACT = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] WR  = 3'd3;
    localparam logic [2:0] PRE = 3'd4;
    localparam logic [2:0] REF = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = 3'd0;
    logic [2:0]    in_bank = 3'd0;
    logic [AW-1:0] in_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2:0]    out_op;
    logic [2:0]    out_bank;
    logic [AW-1:0] out_addr;
    logic [NB-1:0] bank_open;
    logic          err_pulse;
    logic          stall;

    int n_tests = 0;
    int n_fail = 0;

    ddr_cmd_timing_gate dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_bank(in_bank), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_bank(out_bank), .out_addr(out_addr),
        .bank_open(bank_open), .err_pulse(err_pulse), .stall(stall)
    );

    always #5 clk = ~clk;

    // Reference model: absolute cycle numbers at which each command becomes legal.
    int            m_cyc = 0;
    bit            m_open [NB];
    int            m_act_ok [NB];
    int            m_rw_ok [NB];
    int            m_pre_ok [NB];
    int            m_ccd_ok = 0;
    bit            m_ov = 0;
    bit            m_err = 0;
    logic [2:0]    m_op = '0;
    logic [2:0]    m_bank = '0;
    logic [AW-1:0] m_addr = '0;

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 0;
            m_act_ok[i] = 0;
            m_rw_ok[i] = 0;
            m_pre_ok[i] = 0;
        end
        m_ccd_ok = 0;
        m_ov = 0;
        m_err = 0;
        m_op = '0;
        m_bank = '0;
        m_addr = '0;
    endtask

    function automatic bit m_bad(logic [2:0] op, int b);
        case (op)
            ACT: return m_open[b];
            RD, WR, PRE: return !m_open[b];
            NOP, REF: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic bit m_ready(logic [2:0] op, int b);
        bit ok;
        ok = 1;
        case (op)
            ACT: ok = m_open[b] || (m_cyc >= m_act_ok[b]);
            RD, WR: ok = !m_open[b] || (m_cyc >= m_rw_ok[b] && m_cyc >= m_ccd_ok);
            PRE: ok = !m_open[b] || (m_cyc >= m_pre_ok[b]);
            REF: begin
                for (int i = 0; i < NB; i++)
                    if (m_open[i] || m_cyc < m_act_ok[i]) ok = 0;
            end
            default: ok = 1;
        endcase
        return ok && (!m_ov || out_ready);
    endfunction

    function automatic logic [NB-1:0] m_open_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_open[i];
        return v;
    endfunction

    task automatic drive(bit v, logic [2:0] op, int b, int a);
        in_valid = v;
        in_op = op;
        in_bank = 3'(b);
        in_addr = AW'(a);
    endtask

    // Advance one clock, updating the model from the presented inputs.
    task automatic tick();
        bit acc, bad, fwd;
        logic [2:0] op;
        int b;
        op = in_op;
        b = int'(in_bank);
        acc = in_valid && m_ready(op, b);
        bad = m_bad(op, b);
        fwd = acc && !bad && op != NOP;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            m_err = acc && bad;
            if (fwd) begin
                case (op)
                    ACT: begin
                        m_open[b] = 1;
                        m_rw_ok[b] = m_cyc + T_RCD;
                        m_pre_ok[b] = m_cyc + T_RAS;
                    end
                    RD, WR: m_ccd_ok = m_cyc + T_CCD;
                    PRE: begin
                        m_open[b] = 0;
                        m_act_ok[b] = m_cyc + T_RP;
                    end
                    default: ;
                endcase
                m_ov = 1;
                m_op = op;
                m_bank = 3'(b);
                m_addr = in_addr;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
        m_cyc++;
        #1;
    endtask

    task automatic do_reset();
        drive(0, NOP, 0, 0);
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        out_ready = 1;
        drive(1, ACT, 3, 'h1f);
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_err: got %b%b want 00", out_valid, err_pulse);
        end
        n_tests++;
        if (bank_open !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bank_open: got %h want 00", bank_open);
        end
        n_tests++;
        if ({out_op, out_bank, out_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h/%h/%h want 0", out_op, out_bank, out_addr);
        end
        rst = 0;
        drive(1, ACT, 3, 'h1f);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_act: got ready=%b stall=%b want 1/0", in_ready, stall);
        end
        drive(1, REF, 0, 0);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ref: got %b want 1", in_ready);
        end
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_act_rd();
        int acc_at;
        drive(1, ACT, 0, 'h123);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL act_ready: got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_op !== ACT || out_bank !== 3'd0 || out_addr !== 17'h123) begin
            n_fail++;
            $display("FAIL act_latency: got v=%b op=%0d b=%0d a=%h want 1/1/0/123",
                     out_valid, out_op, out_bank, out_addr);
        end
        drive(1, RD, 0, 'h55);
        acc_at = -1;
        for (int k = 1; k <= 40 && acc_at < 0; k++) begin
            #1;
            n_tests++;
            if (in_ready !== (k >= T_RCD) || stall !== (k < T_RCD)) begin
                n_fail++;
                $display("FAIL trcd_k%0d: got ready=%b stall=%b want %b", k, in_ready, stall, k >= T_RCD);
            end
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at != T_RCD) begin
            n_fail++;
            $display("FAIL trcd_accept: got %0d want %0d", acc_at, T_RCD);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_op !== RD || out_addr !== 17'h55) begin
            n_fail++;
            $display("FAIL rd_out: got v=%b op=%0d a=%h want 1/2/55", out_valid, out_op, out_addr);
        end
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_pre_act();
        int acc_at;
        drive(1, ACT, 2, 'h7);
        tick();
        drive(1, PRE, 2, 0);
        acc_at = -1;
        for (int k = 1; k <= 60 && acc_at < 0; k++) begin
            #1;
            n_tests++;
            if (in_ready !== (k >= T_RAS)) begin
                n_fail++;
                $display("FAIL tras_k%0d: got %b want %b", k, in_ready, k >= T_RAS);
            end
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at != T_RAS) begin
            n_fail++;
            $display("FAIL tras_accept: got %0d want %0d", acc_at, T_RAS);
        end
        n_tests++;
        if (bank_open[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_close: got %b want 0", bank_open[2]);
        end
        drive(1, ACT, 2, 'h8);
        acc_at = -1;
        for (int k = 1; k <= 40 && acc_at < 0; k++) begin
            #1;
            n_tests++;
            if (in_ready !== (k >= T_RP)) begin
                n_fail++;
                $display("FAIL trp_k%0d: got %b want %b", k, in_ready, k >= T_RP);
            end
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at != T_RP) begin
            n_fail++;
            $display("FAIL trp_accept: got %0d want %0d", acc_at, T_RP);
        end
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1, RD, 1, 'h9);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_rd_ready: got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || err_pulse !== 1'b1 || bank_open !== 8'h00) begin
            n_fail++;
            $display("FAIL illegal_rd: got v=%b err=%b open=%h want 0/1/00", out_valid, err_pulse, bank_open);
        end
        drive(0, NOP, 0, 0);
        tick();
        n_tests++;
        if (err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b want 0", err_pulse);
        end
        drive(1, 3'd6, 0, 0);
        tick();
        n_tests++;
        if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_op: got err=%b v=%b want 1/0", err_pulse, out_valid);
        end
        drive(1, ACT, 4, 0);
        tick();
        drive(1, ACT, 4, 0);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL act_open_ready: got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (err_pulse !== 1'b1 || out_valid !== 1'b0 || bank_open !== 8'h10) begin
            n_fail++;
            $display("FAIL act_open: got err=%b v=%b open=%h want 1/0/10", err_pulse, out_valid, bank_open);
        end
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        int acc_at;
        do_reset();
        drive(1, ACT, 0, 0);
        tick();
        drive(1, ACT, 3, 0);
        tick();
        drive(1, RD, 0, 'h10);
        acc_at = -1;
        for (int k = 0; k < 40 && acc_at < 0; k++) begin
            #1;
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at < 0) begin
            n_fail++;
            $display("FAIL rd_b0_timeout: got none want accept");
        end
        drive(1, RD, 3, 'h30);
        acc_at = -1;
        for (int k = 1; k <= 20 && acc_at < 0; k++) begin
            #1;
            n_tests++;
            if (in_ready !== (k >= T_CCD)) begin
                n_fail++;
                $display("FAIL tccd_k%0d: got %b want %b", k, in_ready, k >= T_CCD);
            end
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at != T_CCD || out_bank !== 3'd3 || out_op !== RD) begin
            n_fail++;
            $display("FAIL tccd_accept: got %0d b=%0d want %0d b=3", acc_at, out_bank, T_CCD);
        end
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) tick();
        out_ready = 0;
        drive(1, WR, 0, 'h1abc);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_wr_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1, RD, 3, 'h77);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (in_ready !== 1'b0 || stall !== 1'b1 || out_valid !== 1'b1 ||
                out_op !== WR || out_bank !== 3'd0 || out_addr !== 17'h1abc) begin
                n_fail++;
                $display("FAIL bp_hold_k%0d: got r=%b v=%b op=%0d b=%0d a=%h want 0/1/3/0/1abc",
                         k, in_ready, out_valid, out_op, out_bank, out_addr);
            end
            tick();
        end
        out_ready = 1;
        drive(0, NOP, 0, 0);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== 17'h1abc) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b a=%h want 1/1abc", out_valid, out_addr);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: got %b want 0", out_valid);
        end
    endtask

    task automatic test_ref_reset();
        int acc_at;
        do_reset();
        drive(1, ACT, 5, 0);
        tick();
        drive(1, REF, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ref_open_stall: got %b want 0", in_ready);
            end
            tick();
        end
        drive(1, PRE, 5, 0);
        acc_at = -1;
        for (int k = 0; k < 50 && acc_at < 0; k++) begin
            #1;
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at < 0) begin
            n_fail++;
            $display("FAIL pre_b5_timeout: got none want accept");
        end
        drive(1, REF, 0, 0);
        acc_at = -1;
        for (int k = 1; k <= 30 && acc_at < 0; k++) begin
            #1;
            n_tests++;
            if (in_ready !== (k >= T_RP)) begin
                n_fail++;
                $display("FAIL ref_trp_k%0d: got %b want %b", k, in_ready, k >= T_RP);
            end
            if (in_ready === 1'b1) acc_at = k;
            tick();
        end
        n_tests++;
        if (acc_at != T_RP || out_op !== REF) begin
            n_fail++;
            $display("FAIL ref_accept: got %0d op=%0d want %0d op=5", acc_at, out_op, T_RP);
        end
        drive(1, ACT, 5, 0);
        tick();
        out_ready = 0;
        drive(1, REF, 0, 0);
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ref_stall2: got %b want 0", in_ready);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if (out_valid !== 1'b0 || bank_open !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b open=%h want 0/00", out_valid, bank_open);
        end
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ref_after_reset: got %b want 1", in_ready);
        end
        out_ready = 1;
        drive(0, NOP, 0, 0);
        tick();
    endtask

    task automatic test_random();
        int r;
        logic [2:0] op;
        bit exp_r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 10) op = NOP;
            else if (r < 40) op = ACT;
            else if (r < 65) op = ($urandom_range(0, 1) != 0) ? RD : WR;
            else if (r < 88) op = PRE;
            else if (r < 94) op = REF;
            else op = 3'(6 + $urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 9) < 7, op, $urandom_range(0, NB - 1), $urandom);
            #1;
            exp_r = m_ready(in_op, int'(in_bank));
            n_tests++;
            if (in_ready !== exp_r || stall !== (in_valid && !exp_r)) begin
                n_fail++;
                $display("FAIL rnd_ready c%0d: got r=%b s=%b want r=%b", c, in_ready, stall, exp_r);
            end
            tick();
            n_tests++;
            if (out_valid !== m_ov || err_pulse !== m_err || bank_open !== m_open_vec()) begin
                n_fail++;
                $display("FAIL rnd_state c%0d: got v=%b e=%b o=%h want %b/%b/%h",
                         c, out_valid, err_pulse, bank_open, m_ov, m_err, m_open_vec());
            end
            if (m_ov) begin
                n_tests++;
                if ({out_op, out_bank, out_addr} !== {m_op, m_bank, m_addr}) begin
                    n_fail++;
                    $display("FAIL rnd_data c%0d: got %0d/%0d/%h want %0d/%0d/%h",
                             c, out_op, out_bank, out_addr, m_op, m_bank, m_addr);
                end
            end
        end
        drive(0, NOP, 0, 0);
        out_ready = 1;
        tick();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_act_rd();
        test_pre_act();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_ref_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_timing_gate.md
DDR_CMD_TIMING_GATE -- requirements
Module: ddr_cmd_timing_gate

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of tracked banks (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 17, row/column payload width.
REQ-003 SHALL have parameters tRCD_CYC=14, tRP_CYC=14, tRAS_CYC=32, tCCD_CYC=4: minimum cycles between the named command pairs.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1; in_op  in  3  opcode (0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 reserved); in_bank  in  log2(NUM_BANKS); in_addr  in  ADDR_W.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_op  out  3; out_bank  out  log2(NUM_BANKS); out_addr  out  ADDR_W.
REQ-007 SHALL have ports: bank_open  out  NUM_BANKS  per-bank open-row bitmap; err_pulse  out  1  one-cycle illegal-command flag; stall  out  1  in_valid high and in_ready low.

Function
REQ-008 SHALL sit between the refresh/command engine output and the DFI stage, forwarding only timing-legal commands.
REQ-009 SHALL hold one registered output stage; accepted legal command appears on out_* the cycle after acceptance (latency 1).
REQ-010 SHALL compute in_ready = legal(in_op,in_bank) AND (!out_valid OR out_ready); acceptance = in_valid AND in_ready.
REQ-011 SHALL hold out_* stable while out_valid high and out_ready low; out_valid clears after handshake with no new acceptance.
REQ-012 SHALL keep per bank: open bit, tRCD counter, tRP counter, tRAS counter; plus one global tCCD counter; each counter width $clog2(max param+1).
REQ-013 SHALL decrement every non-zero counter by 1 per cycle, saturating at 0, independent of handshakes.
REQ-014 ACT legal iff bank closed and its tRP counter == 0; on acceptance: open<=1, tRCD<=tRCD_CYC, tRAS<=tRAS_CYC.
REQ-015 RD/WR legal iff bank open, its tRCD == 0 and tCCD == 0; on acceptance: tCCD<=tCCD_CYC.
REQ-016 PRE legal iff bank open and its tRAS == 0; on acceptance: open<=0, tRP<=tRP_CYC.
REQ-017 REF legal iff all banks closed and all tRP counters == 0; no counter update.
REQ-018 NOP SHALL be accepted whenever output stage free, and SHALL NOT be forwarded (out_valid unchanged by it).
REQ-019 Illegal-by-state commands (RD/WR/PRE to closed bank, ACT to open bank, reserved opcode) SHALL be accepted when output stage free, dropped, and raise err_pulse for exactly the cycle after acceptance; no state change.
REQ-020 Timing-not-met commands (correct bank state, counter non-zero) SHALL be stalled (in_ready=0), never dropped.
REQ-021 Counter load on acceptance SHALL override the same-cycle decrement for that counter.
REQ-022 in_ready SHALL be combinational from in_*, counters and output-stage state; no combinational path from in_valid to in_ready.
REQ-023 bank_open SHALL reflect registered open bits (updated the cycle after acceptance).
REQ-024 stall SHALL equal in_valid AND !in_ready, combinational.

Reset
REQ-025 While rst high at a clk edge: out_valid=0, out_op/out_bank/out_addr=0, all open bits=0, all counters=0, err_pulse=0.
REQ-026 Reset asserted mid-operation SHALL discard any held output command and all bank state without completing the handshake.
REQ-027 First cycle after reset release: ACT to any bank and REF SHALL be legal.

Verification
REQ-028 ACT b0 accepted at cycle T, RD b0 presented T+1 -> in_ready=0 until T+14, RD accepted at T+14, out_valid at T+15.
REQ-029 ACT b2 at T, PRE b2 presented immediately -> stall until T+32; then ACT b2 stalled until 14 cycles after PRE acceptance.
REQ-030 RD b1 to closed bank -> accepted, not forwarded, err_pulse=1 for one cycle, bank_open unchanged (0x00).
REQ-031 b0 and b3 open, back-to-back RD b0 then RD b3 -> second accepted exactly 4 cycles after first.
REQ-032 out_ready held low 5 cycles with command in output stage -> out_* stable, in_ready=0 throughout, no loss or duplication.
REQ-033 REF with b5 open -> stalled; after PRE b5 and 14 cycles, REF accepted; rst pulsed mid-stall -> out_valid=0, bank_open=0x00 next cycle.
